// File: rtl/rv_fetch_req_pkg.sv
// Shared definitions for the instruction fetch request path.
package rv_fetch_req_pkg;

    localparam int unsigned InstrBusWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/rv_add.sv
// Plain unsigned adder, wraps modulo 2^WIDTH.
module rv_add #(
    parameter int unsigned WIDTH = 14
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/rv_fetch_skid.sv
// Response skid queue: DEPTH x InstrBusWidth ring buffer with synchronous clear.
module rv_fetch_skid
    import rv_fetch_req_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [InstrBusWidth-1:0]     i_wdata,
    input  logic                         i_pop,
    output logic [InstrBusWidth-1:0]     o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [InstrBusWidth-1:0] mem_q [DEPTH];
    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [CW-1:0]            count_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (i_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/rv_fetch_req.sv
// Instruction fetch requester: issues word fetches, kills stale responses after a
// redirect and forwards live words to the fetch buffer through a skid queue.
module rv_fetch_req
    import rv_fetch_req_pkg::*;
#(
    parameter int unsigned IADDR_SPACE_BITS = 16,
    parameter int unsigned SKID_DEPTH       = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [IADDR_SPACE_BITS-1:1] i_reset_pc,
    input  logic                        i_redirect,
    input  logic [IADDR_SPACE_BITS-1:1] i_redirect_pc,
    output logic                        o_instr_req,
    output logic [IADDR_SPACE_BITS-1:2] o_instr_addr,
    input  logic                        i_instr_ack,
    input  logic                        i_instr_rvalid,
    input  logic [InstrBusWidth-1:0]    i_instr_rdata,
    input  logic                        i_buf_not_full,
    output logic                        o_push,
    output logic [InstrBusWidth-1:0]    o_data,
    output logic [IADDR_SPACE_BITS-1:1] o_buf_pc,
    output logic                        o_buf_flush
);

    localparam int unsigned WAW = IADDR_SPACE_BITS - 2;
    localparam int unsigned CW  = $clog2(SKID_DEPTH + 1);
    localparam logic [CW:0] DepthLim = (CW + 1)'(SKID_DEPTH);

    fetch_state_e               state_q;
    logic [IADDR_SPACE_BITS-1:2] fetch_addr_q;
    logic [IADDR_SPACE_BITS-1:2] fetch_addr_inc;
    logic [IADDR_SPACE_BITS-1:1] buf_pc_q;
    logic                       buf_flush_q;
    logic [CW-1:0]              inflight_q;
    logic [CW-1:0]              inflight_d;
    logic [CW-1:0]              kill_cnt_q;
    logic [CW-1:0]              kill_dec;
    logic [CW-1:0]              occ;

    logic                       req;
    logic                       ack_xfer;
    logic                       kill_resp;
    logic                       live_resp;
    logic                       bypass;
    logic                       q_pop;
    logic                       q_push;
    logic [InstrBusWidth-1:0]   q_rdata;

    // The in-flight plus queued sum only grows on an ack, so a raised request
    // stays raised (with a stable address) until it is accepted.
    assign req      = (state_q == StRun) && (({1'b0, inflight_q} + {1'b0, occ}) < DepthLim);
    assign ack_xfer = req && i_instr_ack;

    assign inflight_d = inflight_q + CW'(ack_xfer) - CW'(i_instr_rvalid);
    assign kill_dec   = kill_cnt_q - CW'(i_instr_rvalid && (kill_cnt_q != '0));

    assign kill_resp = i_instr_rvalid && (i_redirect || (kill_cnt_q != '0) || (state_q == StIdle));
    assign live_resp = i_instr_rvalid && !kill_resp;
    assign q_pop     = !i_redirect && (occ != '0) && i_buf_not_full;
    assign bypass    = live_resp && (occ == '0) && i_buf_not_full;
    assign q_push    = live_resp && !bypass;

    rv_add #(
        .WIDTH (WAW)
    ) u_add (
        .i_a   (fetch_addr_q),
        .i_b   (WAW'(1)),
        .o_sum (fetch_addr_inc)
    );

    rv_fetch_skid #(
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_redirect),
        .i_push    (q_push),
        .i_wdata   (i_instr_rdata),
        .i_pop     (q_pop),
        .o_rdata   (q_rdata),
        .o_count   (occ)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            inflight_q   <= '0;
            kill_cnt_q   <= '0;
            buf_flush_q  <= 1'b0;
            fetch_addr_q <= i_reset_pc[IADDR_SPACE_BITS-1:2];
            buf_pc_q     <= i_reset_pc;
        end else begin
            inflight_q  <= inflight_d;
            buf_flush_q <= i_redirect;
            if (i_redirect) begin
                // Everything still outstanding after this edge belongs to the old stream.
                kill_cnt_q   <= inflight_d;
                fetch_addr_q <= i_redirect_pc[IADDR_SPACE_BITS-1:2];
                buf_pc_q     <= i_redirect_pc;
                state_q      <= (inflight_d != '0) ? StDrain : StRun;
            end else begin
                kill_cnt_q <= kill_dec;
                if (ack_xfer) begin
                    fetch_addr_q <= fetch_addr_inc;
                end
                unique case (state_q)
                    StIdle:  state_q <= StRun;
                    StRun:   state_q <= StRun;
                    StDrain: state_q <= (kill_dec == '0) ? StRun : StDrain;
                endcase
            end
        end
    end

    assign o_instr_req  = req;
    assign o_instr_addr = req ? fetch_addr_q : '0;
    assign o_push       = q_pop || bypass;
    assign o_data       = q_pop ? q_rdata : (bypass ? i_instr_rdata : '0);
    assign o_buf_pc     = buf_pc_q;
    assign o_buf_flush  = buf_flush_q;

endmodule

// File: tb/tb_rv_fetch_req.sv
// Randomized bench for rv_fetch_req with a queue-based model of the fetch stream.
module tb_rv_fetch_req;

    localparam int unsigned IAW   = 16;
    localparam int unsigned DEPTH = 2;
    localparam int          WORDS = 1 << (IAW - 2);

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic [IAW-1:1]  i_reset_pc;
    logic            i_redirect;
    logic [IAW-1:1]  i_redirect_pc;
    logic            o_instr_req;
    logic [IAW-1:2]  o_instr_addr;
    logic            i_instr_ack;
    logic            i_instr_rvalid;
    logic [31:0]     i_instr_rdata;
    logic            i_buf_not_full;
    logic            o_push;
    logic [31:0]     o_data;
    logic [IAW-1:1]  o_buf_pc;
    logic            o_buf_flush;

    rv_fetch_req #(
        .IADDR_SPACE_BITS (IAW),
        .SKID_DEPTH       (DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_reset_pc     (i_reset_pc),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_instr_req    (o_instr_req),
        .o_instr_addr   (o_instr_addr),
        .i_instr_ack    (i_instr_ack),
        .i_instr_rvalid (i_instr_rvalid),
        .i_instr_rdata  (i_instr_rdata),
        .i_buf_not_full (i_buf_not_full),
        .o_push         (o_push),
        .o_data         (o_data),
        .o_buf_pc       (o_buf_pc),
        .o_buf_flush    (o_buf_flush)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          live;
        logic [31:0] data;
    } out_t;

    typedef struct {
        int word;
        int ready;
    } bus_t;

    out_t        out_q[$];   // requests accepted but not yet answered, oldest first
    logic [31:0] skid_q[$];  // live words answered but not yet pushed
    bus_t        bus_q[$];   // slave side view of the same requests
    int          acc_q[$];   // word addresses of accepted requests

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_addr;
    int          m_buf_pc;
    bit          m_idle;
    bit          m_flush;
    int          ack_pct, rv_pct, nf_pct, redir_pct;
    int          redir_target;
    bit          force_redir;
    bit          pushed;
    logic [31:0] first_push_data;
    int          flush_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic model_reset(input int byte_pc);
        out_q.delete();
        skid_q.delete();
        bus_q.delete();
        acc_q.delete();
        m_addr   = (byte_pc >> 2) % WORDS;
        m_buf_pc = (byte_pc >> 1) % (WORDS * 2);
        m_idle   = 1'b1;
        m_flush  = 1'b0;
    endtask

    task automatic step();
        bit          redir, exp_req, exp_push, resp_live, bypass, pop;
        int          tgt, dead;
        logic [31:0] exp_data, resp_data;
        out_t        e;

        if (force_redir) begin
            redir = 1'b1;
            tgt   = redir_target;
        end else begin
            redir = !m_idle && ($urandom_range(99) < redir_pct);
            tgt   = int'($urandom_range(0, 32767)) * 2;
        end
        i_redirect     = redir;
        i_redirect_pc  = 15'(tgt >> 1);
        i_instr_ack    = ($urandom_range(99) < ack_pct);
        i_buf_not_full = ($urandom_range(99) < nf_pct);
        i_instr_rvalid = 1'b0;
        i_instr_rdata  = $urandom;
        if (bus_q.size() > 0 && bus_q[0].ready <= cyc && $urandom_range(99) < rv_pct) begin
            i_instr_rvalid = 1'b1;
            i_instr_rdata  = mem_word(bus_q[0].word);
        end
        #1;

        dead = 0;
        foreach (out_q[i]) if (!out_q[i].live) dead++;
        exp_req = !m_idle && (dead == 0) && (out_q.size() + skid_q.size() < DEPTH);
        check("req", 32'(o_instr_req), 32'(exp_req));
        check("buf_flush", 32'(o_buf_flush), 32'(m_flush));
        check("buf_pc", 32'(o_buf_pc), 32'(m_buf_pc));
        if (o_buf_flush) flush_cnt++;

        resp_live = 1'b0;
        resp_data = '0;
        if (i_instr_rvalid) begin
            e = out_q.pop_front();
            void'(bus_q.pop_front());
            resp_live = e.live && !redir;
            resp_data = e.data;
        end
        pop      = !redir && (skid_q.size() > 0) && i_buf_not_full;
        bypass   = resp_live && (skid_q.size() == 0) && i_buf_not_full;
        exp_push = pop || bypass;
        exp_data = resp_data;
        if (pop) exp_data = skid_q[0];
        check("push", 32'(o_push), 32'(exp_push));
        if (exp_push) check("data", o_data, exp_data);
        if (o_push && !pushed) begin
            pushed          = 1'b1;
            first_push_data = o_data;
        end
        if (pop) void'(skid_q.pop_front());
        if (resp_live && !bypass) skid_q.push_back(resp_data);

        if (o_instr_req && i_instr_ack) begin
            check("addr", 32'(o_instr_addr), 32'(m_addr));
            out_q.push_back('{live: 1'b1, data: mem_word(m_addr)});
            bus_q.push_back('{word: int'(o_instr_addr), ready: cyc + 1});
            acc_q.push_back(int'(o_instr_addr));
            m_addr = (m_addr + 1) % WORDS;
        end
        if (redir) begin
            foreach (out_q[i]) out_q[i].live = 1'b0;
            skid_q.delete();
            m_addr   = (tgt >> 2) % WORDS;
            m_buf_pc = (tgt >> 1) % (WORDS * 2);
        end
        m_flush = redir;
        m_idle  = 1'b0;

        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic knobs(input int a, input int r, input int n, input int d);
        ack_pct   = a;
        rv_pct    = r;
        nf_pct    = n;
        redir_pct = d;
    endtask

    // Redirect now, then require exactly one flush and the target word as first push.
    task automatic redirect_and_expect(input string tag, input int byte_pc);
        int budget;
        redir_target = byte_pc;
        force_redir  = 1'b1;
        flush_cnt    = 0;
        step();
        force_redir = 1'b0;
        pushed      = 1'b0;
        knobs(100, 100, 100, 0);
        budget = 0;
        while (!pushed && budget < 40) begin
            step();
            budget++;
        end
        repeat (4) step();
        check({tag, "_pushed"}, 32'(pushed), 32'd1);
        check({tag, "_first_word"}, first_push_data, mem_word((byte_pc >> 2) % WORDS));
        check({tag, "_flush_pulses"}, 32'(flush_cnt), 32'd1);
    endtask

    initial begin
        int budget;
        int acc_before;

        force_redir    = 1'b0;
        redir_target   = 0;
        pushed         = 1'b0;
        flush_cnt      = 0;
        i_reset_n      = 1'b0;
        i_reset_pc     = 15'(16'h0102 >> 1);
        i_redirect     = 1'b0;
        i_redirect_pc  = '0;
        i_instr_ack    = 1'b0;
        i_instr_rvalid = 1'b0;
        i_instr_rdata  = '0;
        i_buf_not_full = 1'b1;
        knobs(100, 100, 100, 0);

        repeat (2) @(negedge i_clk);
        check("rst_req", 32'(o_instr_req), 32'd0);
        check("rst_push", 32'(o_push), 32'd0);
        check("rst_flush", 32'(o_buf_flush), 32'd0);
        check("rst_addr", 32'(o_instr_addr), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_buf_pc", 32'(o_buf_pc), 32'h0081);

        // Streaming from the reset address.
        model_reset(16'h0102);
        i_reset_n = 1'b1;
        repeat (12) step();
        check("stream_n", 32'(acc_q.size() >= 3), 32'd1);
        if (acc_q.size() >= 3) begin
            check("stream_a0", 32'(acc_q[0]), 32'h0040);
            check("stream_a1", 32'(acc_q[1]), 32'h0041);
            check("stream_a2", 32'(acc_q[2]), 32'h0042);
        end

        // Buffer full for ten cycles.
        acc_before = acc_q.size();
        knobs(100, 100, 0, 0);
        repeat (10) step();
        check("full_req_bound", 32'(acc_q.size() - acc_before <= DEPTH), 32'd1);
        check("full_skid_fill", 32'(skid_q.size()), 32'(DEPTH));
        knobs(100, 100, 100, 0);
        repeat (10) step();

        // Build two outstanding requests, then redirect with no response that cycle.
        knobs(100, 0, 100, 0);
        budget = 0;
        while (out_q.size() < DEPTH && budget < 10) begin
            step();
            budget++;
        end
        check("two_inflight", 32'(out_q.size()), 32'(DEPTH));
        redirect_and_expect("redir0200", 16'h0200);

        // Redirect while streaming: ack and rvalid land on the redirect cycle.
        knobs(100, 100, 100, 0);
        repeat (6) step();
        redirect_and_expect("redir_ack_rv", 16'h1234);

        // Address wrap from the top word.
        redirect_and_expect("redir_top", 16'hFFFC);
        acc_q.delete();
        redir_target = 16'hFFFC;
        force_redir  = 1'b1;
        step();
        force_redir = 1'b0;
        acc_q.delete();
        repeat (8) step();
        check("wrap_n", 32'(acc_q.size() >= 2), 32'd1);
        if (acc_q.size() >= 2) begin
            check("wrap_top", 32'(acc_q[0]), 32'h3FFF);
            check("wrap_zero", 32'(acc_q[1]), 32'h0000);
        end

        // Random traffic.
        for (int blk = 0; blk < 15; blk++) begin
            knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                  $urandom_range(0, 6));
            repeat (200) step();
        end

        // Asynchronous reset in the middle of a burst.
        knobs(100, 100, 100, 0);
        repeat (6) step();
        #2;
        i_reset_pc     = 15'(16'h0480 >> 1);
        i_reset_n      = 1'b0;
        i_instr_rvalid = 1'b0;
        i_instr_ack    = 1'b0;
        i_redirect     = 1'b0;
        #1;
        check("arst_req", 32'(o_instr_req), 32'd0);
        check("arst_push", 32'(o_push), 32'd0);
        check("arst_flush", 32'(o_buf_flush), 32'd0);
        check("arst_addr", 32'(o_instr_addr), 32'd0);
        check("arst_data", o_data, 32'd0);
        check("arst_buf_pc", 32'(o_buf_pc), 32'h0240);
        repeat (2) @(negedge i_clk);
        model_reset(16'h0480);
        i_reset_n = 1'b1;
        repeat (10) step();
        check("restart_n", 32'(acc_q.size() >= 1), 32'd1);
        if (acc_q.size() >= 1) check("restart_a0", 32'(acc_q[0]), 32'h0120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
